// File: rtl/hash160_pkg.sv
// Shared Hash160 definitions: digest geometry, transmitter FSM encoding and
// the RIPEMD-160 initial chaining values used by the core.
package hash160_pkg;

    localparam int unsigned HASH160_NUM_BYTES = 20;
    localparam int unsigned HASH160_DIGEST_W  = HASH160_NUM_BYTES * 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SEND = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [31:0] RMD_H0 = 32'h6745_2301;
    localparam logic [31:0] RMD_H1 = 32'hEFCD_AB89;
    localparam logic [31:0] RMD_H2 = 32'h98BA_DCFE;
    localparam logic [31:0] RMD_H3 = 32'h1032_5476;
    localparam logic [31:0] RMD_H4 = 32'hC3D2_E1F0;

endpackage

// File: rtl/hash160_edge_arm.sv
// Rising-edge detector on the core's level-held digest valid, gated by an arm
// flag that only re-arms once the valid level has been seen low.
module hash160_edge_arm (
    input  logic clk,
    input  logic rst_n,
    input  logic valid,
    input  logic capture,
    output logic start
);

    logic valid_d;
    logic armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d <= 1'b0;
            armed   <= 1'b1;
        end else begin
            valid_d <= valid;
            if (capture) begin
                armed <= 1'b0;
            end else if (!valid) begin
                armed <= 1'b1;
            end
        end
    end

    assign start = valid & ~valid_d & armed;

endmodule

// File: rtl/hash160_digest_tx.sv
// Byte-serial Hash160 digest transmitter, MSB byte first over valid/ready.
// Optional trailing XOR checksum byte when HASH160_TX_CHKSUM_EN is defined.
module hash160_digest_tx
    import hash160_pkg::*;
#(
    parameter int NUM_BYTES = HASH160_NUM_BYTES,
    parameter int CNT_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic [NUM_BYTES*8-1:0] i_digest,
    output logic [7:0]             o_byte,
    output logic                   o_byte_valid,
    input  logic                   i_byte_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int DW = NUM_BYTES * 8;
`ifdef HASH160_TX_CHKSUM_EN
    localparam int FRAME_LEN = NUM_BYTES + 1;
`else
    localparam int FRAME_LEN = NUM_BYTES;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    logic [1:0]       state_q, state_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start;
    logic             capture;

    assign capture = start & (state_q == ST_IDLE);

    hash160_edge_arm u_edge_arm (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (i_valid),
        .capture (capture),
        .start   (start)
    );

`ifdef HASH160_TX_CHKSUM_EN
    logic [7:0] chk_q, chk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 8'h00;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef HASH160_TX_CHKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d = ST_SEND;
                    shift_d = i_digest;
                    cnt_d   = '0;
`ifdef HASH160_TX_CHKSUM_EN
                    chk_d   = 8'h00;
`endif
                end
            end
            ST_SEND: begin
                if (i_byte_ready) begin
                    shift_d = shift_q << 8;
                    cnt_d   = cnt_q + 1'b1;
`ifdef HASH160_TX_CHKSUM_EN
                    chk_d   = chk_q ^ shift_q[DW-1 -: 8];
                    // After the last digest byte, the checksum becomes the next byte out.
                    if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
                        shift_d[DW-1 -: 8] = chk_q ^ shift_q[DW-1 -: 8];
                    end
`endif
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // The head of the shift register is the presented byte; it is zero outside a frame.
    assign o_byte       = shift_q[DW-1 -: 8];
    assign o_byte_valid = (state_q == ST_SEND);
    assign o_busy       = (state_q == ST_SEND);
    assign o_done       = (state_q == ST_DONE);

endmodule
